// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage and its neighbours: PC handshake, program loader,
// decoder handshake and status. The master modport is the fetch stage itself.
interface instr_fetch_if #(
  parameter int MSB    = 11,
  parameter int INSN_W = 16,
  parameter int OPC_W  = 5,
  parameter int ICNT_W = 16
);
  logic [MSB-1:0]    i_pc;
  logic              o_pc_en;
  logic              i_run;
  logic              i_load_we;
  logic [MSB-1:0]    i_load_addr;
  logic [INSN_W-1:0] i_load_data;
  // o_insn transfers on every rising edge where o_valid && i_ready; while o_valid is
  // high and i_ready low, o_insn is held unchanged and o_valid does not drop.
  logic              o_valid;
  logic              i_ready;
  logic [INSN_W-1:0] o_insn;
  logic [OPC_W-1:0]  o_opcode;
  logic [MSB-1:0]    o_operand;
  logic              o_halted;
  logic [ICNT_W-1:0] o_icount;
  logic [1:0]        o_state;

  modport master (
    input  i_pc, i_run, i_load_we, i_load_addr, i_load_data, i_ready,
    output o_pc_en, o_valid, o_insn, o_opcode, o_operand, o_halted, o_icount, o_state
  );
  modport slave (
    output i_pc, i_run, i_load_we, i_load_addr, i_load_data, i_ready,
    input  o_pc_en, o_valid, o_insn, o_opcode, o_operand, o_halted, o_icount, o_state
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: reads program memory at the external PC, hands one instruction per
// handshake to the decoder, pulses the PC enable on acceptance and stops on HLT.
module instr_fetch #(
  parameter int MSB    = 11,
  parameter int INSN_W = 16,
  parameter int OPC_W  = 5,
  parameter int ICNT_W = 16
) (
  input logic          i_clk,
  input logic          i_rst,
  instr_fetch_if.master bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  logic [1:0]        state;
  logic [INSN_W-1:0] insn;
  logic [ICNT_W-1:0] icount;
  logic [INSN_W-1:0] mem [0:(1<<MSB)-1];
  logic              is_hlt;
  logic              accept;
  logic              load_ok;

  assign is_hlt  = (insn[INSN_W-1 -: OPC_W] == '0);
  assign accept  = (state == S_DELIVER) && bus.i_ready;
  // Loader may only touch memory while the core is not fetching.
  assign load_ok = bus.i_load_we && !i_rst && ((state == S_IDLE) || (state == S_HALT));

  always_ff @(posedge i_clk) begin
    if (load_ok) mem[bus.i_load_addr] <= bus.i_load_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      insn   <= '0;
      icount <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.i_run) state <= S_FETCH;
        S_FETCH: begin
          insn  <= mem[bus.i_pc];
          state <= S_DELIVER;
        end
        S_DELIVER: if (bus.i_ready) begin
          icount <= icount + ICNT_W'(1);
          state  <= is_hlt ? S_HALT : S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC enable is combinational so the PC steps on the same edge that retires the insn.
  assign bus.o_pc_en   = accept && !is_hlt;
  assign bus.o_valid   = (state == S_DELIVER);
  assign bus.o_insn    = insn;
  assign bus.o_opcode  = insn[INSN_W-1 -: OPC_W];
  assign bus.o_operand = insn[MSB-1:0];
  assign bus.o_halted  = (state == S_HALT);
  assign bus.o_icount  = icount;
  assign bus.o_state   = state;
endmodule
